// File: rtl/instr_decode_queue_if.sv
// Fetch-side and decode-side signal bundle for instr_decode_queue.
// The slave modport is the queue; the master modport is fetch plus decode/rename.
interface instr_decode_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          IN_invalidate;
    logic [63:0]   IN_instr;
    logic [1:0]    IN_instrValid;
    logic [1:0]    IN_branchPred;
    logic [11:0]   IN_branchID;
    logic [63:0]   IN_pc;
    logic          OUT_full;
    logic          IN_stall;
    logic [63:0]   OUT_instr;
    logic [1:0]    OUT_instrValid;
    logic [1:0]    OUT_branchPred;
    logic [11:0]   OUT_branchID;
    logic [63:0]   OUT_pc;
    logic [CW-1:0] OUT_count;

    modport master (
        output IN_invalidate, IN_instr, IN_instrValid, IN_branchPred, IN_branchID, IN_pc, IN_stall,
        input  OUT_full, OUT_instr, OUT_instrValid, OUT_branchPred, OUT_branchID, OUT_pc, OUT_count
    );

    modport slave (
        input  IN_invalidate, IN_instr, IN_instrValid, IN_branchPred, IN_branchID, IN_pc, IN_stall,
        output OUT_full, OUT_instr, OUT_instrValid, OUT_branchPred, OUT_branchID, OUT_pc, OUT_count
    );
endinterface

// File: rtl/instr_decode_queue.sv
// Two-wide circular instruction queue feeding a registered decode-input stage.
// Optional build macro DECODE_QUEUE_BYPASS_EN lets inputs skip an empty queue straight into the output stage.
module instr_decode_queue #(
    parameter int NUM_UOPS = 2,
    parameter int DEPTH    = 8
) (
    input  logic                clk,
    input  logic                rst,
    instr_decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic [5:0]  bid;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [CW-1:0] r_wptr;
    logic [CW-1:0] r_rptr;
    logic [1:0]    r_ov;
    entry_t        r_o0;
    entry_t        r_o1;

    entry_t        w_s0, w_s1, w_c0, w_c1, w_r0, w_r1, w_ld0, w_ld1;
    logic [CW-1:0] w_count, w_rptr1, w_wptr1;
    logic          w_full, w_adv, w_bypass, w_do_push;
    logic [1:0]    w_npush, w_npop, w_ld_v;

    assign w_s0 = {bus.IN_instr[31:0],  bus.IN_pc[31:0],  bus.IN_branchPred[0], bus.IN_branchID[5:0]};
    assign w_s1 = {bus.IN_instr[63:32], bus.IN_pc[63:32], bus.IN_branchPred[1], bus.IN_branchID[11:6]};

    // Compaction: a lone slot-1 instruction moves into position 0.
    assign w_c0    = bus.IN_instrValid[0] ? w_s0 : w_s1;
    assign w_c1    = w_s1;
    assign w_npush = {1'b0, bus.IN_instrValid[0]} + {1'b0, bus.IN_instrValid[1]};

    assign w_count = r_wptr - r_rptr;
    assign w_full  = w_count > CW'(DEPTH - 2);
    assign w_adv   = !bus.IN_stall || (r_ov == 2'b00);
    assign w_rptr1 = r_rptr + CW'(1);
    assign w_wptr1 = r_wptr + CW'(1);
    assign w_r0    = r_mem[r_rptr[AW-1:0]];
    assign w_r1    = r_mem[w_rptr1[AW-1:0]];

`ifdef DECODE_QUEUE_BYPASS_EN
    assign w_bypass = (w_count == '0) && w_adv;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_do_push = !w_full && (w_npush != 2'd0) && !w_bypass;

    always_comb begin
        w_npop = 2'd0;
        if (w_adv && !w_bypass) begin
            if (w_count >= CW'(NUM_UOPS)) w_npop = 2'd2;
            else                          w_npop = w_count[1:0];
        end
    end

    always_comb begin
        w_ld_v = 2'b00;
        w_ld0  = w_r0;
        w_ld1  = w_r1;
        if (w_bypass) begin
            w_ld0 = w_c0;
            w_ld1 = w_c1;
            case (w_npush)
                2'd2:    w_ld_v = 2'b11;
                2'd1:    w_ld_v = 2'b01;
                default: w_ld_v = 2'b00;
            endcase
        end else begin
            case (w_npop)
                2'd2:    w_ld_v = 2'b11;
                2'd1:    w_ld_v = 2'b01;
                default: w_ld_v = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ov   <= 2'b00;
            r_o0   <= '0;
            r_o1   <= '0;
        end else if (bus.IN_invalidate) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ov   <= 2'b00;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + CW'(w_npush);
            r_rptr <= r_rptr + CW'(w_npop);
            if (w_adv) begin
                r_ov <= w_ld_v;
                r_o0 <= w_ld0;
                r_o1 <= w_ld1;
            end
        end
    end

    // Storage carries no reset; occupancy is tracked purely by the pointers.
    always_ff @(posedge clk) begin
        if (!rst && !bus.IN_invalidate && w_do_push) begin
            r_mem[r_wptr[AW-1:0]] <= w_c0;
            if (w_npush == 2'd2) r_mem[w_wptr1[AW-1:0]] <= w_c1;
        end
    end

    assign bus.OUT_full       = w_full;
    assign bus.OUT_count      = w_count;
    assign bus.OUT_instrValid = r_ov;
    assign bus.OUT_instr      = {r_o1.instr, r_o0.instr};
    assign bus.OUT_pc         = {r_o1.pc, r_o0.pc};
    assign bus.OUT_branchPred = {r_o1.pred, r_o0.pred};
    assign bus.OUT_branchID   = {r_o1.bid, r_o0.bid};
endmodule

// File: tb/tb_instr_decode_queue.sv
// Self-checking bench for instr_decode_queue: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the decode buffer.
module tb_instr_decode_queue;
    localparam int DEPTH = 8;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        pred;
        logic [5:0]  bid;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_decode_queue_if #(.DEPTH(DEPTH)) bus();

    instr_decode_queue #(.NUM_UOPS(2), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ent_t       m_q[$];
    logic [1:0] m_ov;
    ent_t       m_o [2];
    int         checks = 0;
    int         errors = 0;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.instr = $urandom;
        e.pc    = pc;
        e.pred  = 1'($urandom_range(0, 1));
        e.bid   = 6'($urandom_range(0, 63));
        return e;
    endfunction

    task automatic drive(input logic [1:0] v, input ent_t e0, input ent_t e1);
        bus.IN_instrValid = v;
        bus.IN_instr      = {e1.instr, e0.instr};
        bus.IN_pc         = {e1.pc, e0.pc};
        bus.IN_branchPred = {e1.pred, e0.pred};
        bus.IN_branchID   = {e1.bid, e0.bid};
    endtask

    task automatic idle();
        drive(2'b00, mk($urandom), mk($urandom));
    endtask

    // Reference: a FIFO of entries plus a two-slot output register, updated per edge.
    task automatic model_edge();
        ent_t s [2];
        ent_t p[$];
        int   cnt, n;
        logic adv, byp;
        s[0] = {bus.IN_instr[31:0],  bus.IN_pc[31:0],  bus.IN_branchPred[0], bus.IN_branchID[5:0]};
        s[1] = {bus.IN_instr[63:32], bus.IN_pc[63:32], bus.IN_branchPred[1], bus.IN_branchID[11:6]};
        if (rst) begin
            m_q.delete();
            m_ov = 2'b00;
            m_o[0] = '0;
            m_o[1] = '0;
        end else if (bus.IN_invalidate) begin
            m_q.delete();
            m_ov = 2'b00;
        end else begin
            cnt = m_q.size();
            adv = !bus.IN_stall || (m_ov == 2'b00);
            byp = 1'b0;
            if (cnt <= DEPTH - 2)
                for (int i = 0; i < 2; i++) if (bus.IN_instrValid[i]) p.push_back(s[i]);
`ifdef DECODE_QUEUE_BYPASS_EN
            if (cnt == 0 && adv) begin
                byp  = 1'b1;
                m_ov = (p.size() == 2) ? 2'b11 : (p.size() == 1) ? 2'b01 : 2'b00;
                for (int i = 0; i < p.size(); i++) m_o[i] = p[i];
                p.delete();
            end
`endif
            if (adv && !byp) begin
                n    = (cnt >= 2) ? 2 : cnt;
                m_ov = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
                for (int i = 0; i < n; i++) m_o[i] = m_q.pop_front();
            end
            foreach (p[i]) m_q.push_back(p[i]);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bus.IN_stall = 1'b0;
        bus.IN_invalidate = 1'b0;
        idle();
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.IN_invalidate = 1'($urandom_range(0, 1));
        bus.IN_stall      = 1'($urandom_range(0, 1));
        drive(2'($urandom_range(0, 3)), mk($urandom), mk($urandom));
        step();
        drive(2'($urandom_range(0, 3)), mk($urandom), mk($urandom));
        step();
        checks++;
        if ({bus.OUT_instrValid, bus.OUT_instr, bus.OUT_pc, bus.OUT_branchPred, bus.OUT_branchID} !== '0)
            begin errors++; $display("FAIL reset_outputs: got valid=%b pc=%h instr=%h, want all zero",
                                     bus.OUT_instrValid, bus.OUT_pc, bus.OUT_instr); end
        checks++;
        if (bus.OUT_count !== 4'd0 || bus.OUT_full !== 1'b0)
            begin errors++; $display("FAIL reset_count: got count=%0d full=%b, want 0/0", bus.OUT_count, bus.OUT_full); end
        rst = 1'b0;
        bus.IN_invalidate = 1'b0;
        bus.IN_stall = 1'b0;
        idle();
        step();
    endtask

    task automatic test_basic_flow();
        drive(2'b11, mk(32'h100), mk(32'h104));
        step();
        idle();
`ifndef DECODE_QUEUE_BYPASS_EN
        checks++;
        if (bus.OUT_instrValid !== 2'b00)
            begin errors++; $display("FAIL basic_latency: got valid=%b after edge N, want 00", bus.OUT_instrValid); end
        step();
`endif
        checks++;
        if (bus.OUT_instrValid !== 2'b11 || bus.OUT_pc !== {32'h104, 32'h100})
            begin errors++; $display("FAIL basic_flow: got valid=%b pc=%h, want 11 0000010400000100",
                                     bus.OUT_instrValid, bus.OUT_pc); end
        drain();
    endtask

    task automatic test_compaction();
        ent_t e1;
        e1 = mk(32'h208);
        e1.bid = 6'd5;
        e1.pred = 1'b1;
        drive(2'b10, mk(32'hdead), e1);
        step();
        idle();
`ifndef DECODE_QUEUE_BYPASS_EN
        step();
`endif
        checks++;
        if (bus.OUT_instrValid !== 2'b01 || bus.OUT_pc[31:0] !== 32'h208 || bus.OUT_branchID[5:0] !== 6'd5 ||
            bus.OUT_branchPred[0] !== 1'b1 || bus.OUT_instr[31:0] !== e1.instr)
            begin errors++; $display("FAIL compaction: got valid=%b pc0=%h id0=%0d pred0=%b, want 01 208 5 1",
                                     bus.OUT_instrValid, bus.OUT_pc[31:0], bus.OUT_branchID[5:0], bus.OUT_branchPred[0]); end
        drain();
    endtask

    task automatic test_full();
        logic [31:0] exp;
        bus.IN_stall = 1'b1;
        drive(2'b11, mk(32'h500), mk(32'h504));
        step();
        idle();
        step();
        checks++;
        if (bus.OUT_instrValid !== 2'b11 || bus.OUT_pc !== {32'h504, 32'h500} || bus.OUT_count !== 4'd0)
            begin errors++; $display("FAIL full_head: got valid=%b pc=%h count=%0d, want 11 504/500 0",
                                     bus.OUT_instrValid, bus.OUT_pc, bus.OUT_count); end
        for (int k = 0; k < 3; k++) begin
            drive(2'b11, mk(32'h508 + 32'(8 * k)), mk(32'h50c + 32'(8 * k)));
            step();
        end
        drive(2'b01, mk(32'h520), mk(32'hbad));
        step();
        checks++;
        if (bus.OUT_count !== 4'd7 || bus.OUT_full !== 1'b1)
            begin errors++; $display("FAIL full_flag: got count=%0d full=%b, want 7/1", bus.OUT_count, bus.OUT_full); end
        drive(2'b11, mk(32'h900), mk(32'h904));
        step();
        checks++;
        if (bus.OUT_count !== 4'd7 || bus.OUT_instrValid !== 2'b11 || bus.OUT_pc !== {32'h504, 32'h500})
            begin errors++; $display("FAIL full_ignore: got count=%0d valid=%b pc=%h, want 7 11 504/500",
                                     bus.OUT_count, bus.OUT_instrValid, bus.OUT_pc); end
        idle();
        bus.IN_stall = 1'b0;
        exp = 32'h500;
        for (int k = 0; k < 20; k++) begin
            for (int i = 0; i < 2; i++) if (bus.OUT_instrValid[i]) begin
                checks++;
                if (bus.OUT_pc[32*i +: 32] !== exp)
                    begin errors++; $display("FAIL full_drain: slot%0d got pc=%h, want %h", i, bus.OUT_pc[32*i +: 32], exp); end
                exp += 32'd4;
            end
            step();
        end
        checks++;
        if (exp !== 32'h524 || bus.OUT_count !== 4'd0)
            begin errors++; $display("FAIL full_drain_end: got next_pc=%h count=%0d, want 524 0", exp, bus.OUT_count); end
        drain();
    endtask

    task automatic test_invalidate();
        bit found;
        bus.IN_stall = 1'b1;
        drive(2'b11, mk(32'h600), mk(32'h604));
        step();
        idle();
        step();
        drive(2'b11, mk(32'h608), mk(32'h60c)); step();
        drive(2'b11, mk(32'h610), mk(32'h614)); step();
        drive(2'b01, mk(32'h618), mk(32'h0));   step();
        checks++;
        if (bus.OUT_count !== 4'd5 || bus.OUT_instrValid !== 2'b11)
            begin errors++; $display("FAIL inv_setup: got count=%0d valid=%b, want 5 11", bus.OUT_count, bus.OUT_instrValid); end
        drive(2'b11, mk(32'h700), mk(32'h704));
        bus.IN_invalidate = 1'b1;
        step();
        bus.IN_invalidate = 1'b0;
        idle();
        checks++;
        if (bus.OUT_count !== 4'd0 || bus.OUT_instrValid !== 2'b00 || bus.OUT_full !== 1'b0)
            begin errors++; $display("FAIL inv_flush: got count=%0d valid=%b full=%b, want 0 00 0",
                                     bus.OUT_count, bus.OUT_instrValid, bus.OUT_full); end
        bus.IN_stall = 1'b0;
        drive(2'b01, mk(32'h400), mk(32'h0));
        step();
        idle();
        found = 0;
        for (int k = 0; k < 6 && !found; k++) begin
            if (bus.OUT_instrValid != 2'b00) begin
                found = 1;
                checks++;
                if (bus.OUT_instrValid !== 2'b01 || bus.OUT_pc[31:0] !== 32'h400)
                    begin errors++; $display("FAIL inv_first: got valid=%b pc0=%h, want 01 400",
                                             bus.OUT_instrValid, bus.OUT_pc[31:0]); end
            end else step();
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL inv_first: no output within 6 cycles, want pc 400");
        end
        drain();
    endtask

    task automatic test_wrap_order();
        int sent = 0, rcv = 0, cyc = 0;
        logic [31:0] exp = 32'h1000;
        while (rcv < 80 && cyc < 2000) begin
            bus.IN_stall = ($urandom_range(0, 99) < 30);
            if (sent < 40 && !bus.OUT_full && $urandom_range(0, 99) < 70) begin
                drive(2'b11, mk(32'h1000 + 32'(8 * sent)), mk(32'h1004 + 32'(8 * sent)));
                sent++;
            end else idle();
            if (!bus.IN_stall)
                for (int i = 0; i < 2; i++) if (bus.OUT_instrValid[i]) begin
                    checks++;
                    if (bus.OUT_pc[32*i +: 32] !== exp)
                        begin errors++; $display("FAIL wrap_order: cyc %0d slot%0d got pc=%h, want %h",
                                                 cyc, i, bus.OUT_pc[32*i +: 32], exp); end
                    exp += 32'd4;
                    rcv++;
                end
            step();
            cyc++;
            checks++;
            if (bus.OUT_count !== 4'(m_q.size()) || bus.OUT_instrValid !== m_ov)
                begin errors++; $display("FAIL wrap_state: cyc %0d got count=%0d valid=%b, want %0d %b",
                                         cyc, bus.OUT_count, bus.OUT_instrValid, m_q.size(), m_ov); end
        end
        checks++;
        if (rcv != 80)
            begin errors++; $display("FAIL wrap_timeout: got %0d instructions, want 80", rcv); end
        drain();
    endtask

    task automatic test_random_model();
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.IN_stall      = ($urandom_range(0, 99) < 40);
            bus.IN_invalidate = ($urandom_range(0, 99) < 3);
            if (!bus.OUT_full || $urandom_range(0, 99) < 10)
                drive(2'($urandom_range(0, 3)), mk($urandom), mk($urandom));
            else idle();
            step();
            checks++;
            if (bus.OUT_count !== 4'(m_q.size()) || bus.OUT_full !== (m_q.size() > DEPTH - 2) ||
                bus.OUT_instrValid !== m_ov)
                begin errors++; $display("FAIL rnd_state: cyc %0d got count=%0d full=%b valid=%b, want %0d %b %b",
                                         cyc, bus.OUT_count, bus.OUT_full, bus.OUT_instrValid,
                                         m_q.size(), (m_q.size() > DEPTH - 2), m_ov); end
            for (int i = 0; i < 2; i++) if (m_ov[i]) begin
                checks++;
                if ({bus.OUT_instr[32*i +: 32], bus.OUT_pc[32*i +: 32], bus.OUT_branchPred[i],
                     bus.OUT_branchID[6*i +: 6]} !== m_o[i])
                    begin errors++; $display("FAIL rnd_slot%0d: cyc %0d got pc=%h instr=%h, want pc=%h instr=%h",
                                             i, cyc, bus.OUT_pc[32*i +: 32], bus.OUT_instr[32*i +: 32],
                                             m_o[i].pc, m_o[i].instr); end
            end
        end
        bus.IN_invalidate = 1'b0;
        drain();
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_compaction();
        test_full();
        test_invalidate();
        test_wrap_order();
        test_random_model();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
